param_memory_ctrl: RTL

Clocked, parametrised successor to the 8x16 asynchronous memory, generalised to DATA_W x 2**ADDR_W. Fronts the storage array with a valid/ready request port, per-byte write enables and a registered 1-cycle read response. A hardware init sequencer fills every word with INIT_VAL after reset or on a clear command. It sits between the datapath/CPU load-store unit and on-chip storage.

---
 rtl/param_memory_ctrl.sv | 68 ++++++
 1 files changed

// File: rtl/param_memory_ctrl.sv
// param_memory_ctrl: byte-enabled word memory with a valid/ready request port, 1-cycle read response and an init sequencer
module param_memory_ctrl #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 3,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  input  logic                clr_start,
  output logic                busy
);
  localparam int              DEPTH  = 1 << ADDR_W;
  localparam int              BE_W   = DATA_W / 8;
  localparam logic [ADDR_W:0] LAST   = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [0:0]      S_INIT = 1'b0;
  localparam logic [0:0]      S_IDLE = 1'b1;
  logic [DATA_W-1:0] Mem [0:DEPTH-1];
  logic [0:0]        r_state;
  logic [ADDR_W:0]   r_init_ptr;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              w_accept;
  logic              w_wr;
  logic              w_rd;
  // clr_start blocks acceptance in the same cycle so no request slips into the sweep
  assign busy      = r_state == S_INIT;
  assign req_ready = r_state == S_IDLE && !clr_start;
  assign w_accept  = req_valid && req_ready;
  assign w_wr      = w_accept && req_we;
  assign w_rd      = w_accept && !req_we;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  // sweep pointer walks 0..DEPTH-1 then parks at DEPTH; IDLE re-enters INIT on clr_start
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state    <= S_INIT;
      r_init_ptr <= '0;
    end else if (r_state == S_INIT) begin
      r_init_ptr <= r_init_ptr + 1'b1;
      if (r_init_ptr == LAST) r_state <= S_IDLE;
    end else if (clr_start) begin
      r_state    <= S_INIT;
      r_init_ptr <= '0;
    end
  // read response registered at the accepting edge; data holds until the next read
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_rd;
      if (w_rd) r_rsp_rdata <= Mem[req_addr];
    end
  // storage is not reset: the sweep owns it in INIT, merged byte writes own it in IDLE
  always_ff @(posedge clk)
    if (r_state == S_INIT) Mem[r_init_ptr[ADDR_W-1:0]] <= INIT_VAL;
    else if (w_wr)
      for (int i = 0; i < BE_W; i++)
        if (req_be[i]) Mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
endmodule
